// File: rtl/accl_pair_sequencer_if.sv
// ---------------------------------------------------------------------------
// accl_pair_sequencer_if
// Control and data bundle between the nbody top-level FSM, the body RAMs,
// the getAccl pipeline, the velocity accumulator and accl_pair_sequencer.
//   start/abort/num_bodies : pass control from the top-level FSM
//   rd_addr_i/rd_addr_j    : body RAM read addresses, qualified by issue_valid
//   acc_*                  : tag aligned with getAccl ax/ay, qualified by acc_valid
//   busy/done              : pass status back to the top-level FSM
// master = top-level controller side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface accl_pair_sequencer_if #(
  parameter int BODY_ADDR_WIDTH = 9
);
  logic                       start;
  logic                       abort;
  logic [BODY_ADDR_WIDTH:0]   num_bodies;
  logic [BODY_ADDR_WIDTH-1:0] rd_addr_i;
  logic [BODY_ADDR_WIDTH-1:0] rd_addr_j;
  logic                       issue_valid;
  logic                       acc_valid;
  logic [BODY_ADDR_WIDTH-1:0] acc_i;
  logic                       acc_self;
  logic                       acc_first;
  logic                       acc_last;
  logic                       busy;
  logic                       done;

  modport master (
    output start, abort, num_bodies,
    input  rd_addr_i, rd_addr_j, issue_valid,
    input  acc_valid, acc_i, acc_self, acc_first, acc_last,
    input  busy, done
  );

  modport slave (
    input  start, abort, num_bodies,
    output rd_addr_i, rd_addr_j, issue_valid,
    output acc_valid, acc_i, acc_self, acc_first, acc_last,
    output busy, done
  );
endinterface

// File: rtl/accl_pair_sequencer.sv
// ---------------------------------------------------------------------------
// accl_pair_sequencer
// Walks all n*n (i, j) body pairs for the acceleration phase, one pair per
// cycle, and carries a {valid, i, self, first, last} tag through a delay line
// of PIPE_LAT stages so it lines up with the ax/ay produced by getAccl.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-low
//   bus  : accl_pair_sequencer_if.slave (start/abort/num_bodies in;
//          read addresses, aligned tag and busy/done out)
// ---------------------------------------------------------------------------
module accl_pair_sequencer #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int PIPE_LAT        = 60
) (
  input  logic                clk,
  input  logic                rst,
  accl_pair_sequencer_if.slave bus
);

  // Counters carry one extra bit so n == BODIES is representable.
  localparam int            CW       = BODY_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] BODIES_C = CW'(BODIES);
  localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  typedef struct packed {
    logic                       valid;
    logic [BODY_ADDR_WIDTH-1:0] idx;
    logic                       self_pair;
    logic                       first;
    logic                       last;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{
    valid:     1'b0,
    idx:       {BODY_ADDR_WIDTH{1'b0}},
    self_pair: 1'b0,
    first:     1'b0,
    last:      1'b0
  };

  state_t        state_r, state_s;
  logic [CW-1:0] n_r, n_s, n_clamp_s, n_m1_s;
  logic [CW-1:0] cnt_i_r, cnt_i_s, cnt_j_r, cnt_j_s;
  logic          issue_valid_r, busy_r, done_r;
  logic          line_busy_s;
  tag_t          tag_in_s;
  tag_t          pipe_r [PIPE_LAT];

  assign n_m1_s = n_r - ONE_C;

  // Clamp the requested body count to the RAM capacity.
  always_comb begin
    n_clamp_s = bus.num_bodies;
    if (bus.num_bodies > BODIES_C) begin
      n_clamp_s = BODIES_C;
    end else begin
      n_clamp_s = bus.num_bodies;
    end
  end

  // Build the tag for the pair currently presented on the read addresses.
  always_comb begin
    tag_in_s = TAG_EMPTY;
    if (issue_valid_r) begin
      tag_in_s.valid     = 1'b1;
      tag_in_s.idx       = cnt_i_r[BODY_ADDR_WIDTH-1:0];
      tag_in_s.self_pair = (cnt_i_r == cnt_j_r);
      tag_in_s.first     = (cnt_j_r == ZERO_C);
      tag_in_s.last      = (cnt_j_r == n_m1_s);
    end else begin
      tag_in_s = TAG_EMPTY;
    end
  end

  // Something is still in flight after the next edge: the live issue slot or
  // any stage except the last (the last one retires on this edge).
  always_comb begin
    line_busy_s = issue_valid_r;
    for (int k = 0; k < PIPE_LAT - 1; k++) begin
      line_busy_s = line_busy_s | pipe_r[k].valid;
    end
  end

  // Next-state and pair-counter logic.
  always_comb begin
    state_s = state_r;
    n_s     = n_r;
    cnt_i_s = cnt_i_r;
    cnt_j_s = cnt_j_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else if (bus.start) begin
          n_s     = n_clamp_s;
          cnt_i_s = ZERO_C;
          cnt_j_s = ZERO_C;
          // An empty pass takes one DRAIN cycle (nothing in flight) so busy
          // is visible for a cycle before the done pulse.
          if (n_clamp_s == ZERO_C) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
          cnt_i_s = ZERO_C;
          cnt_j_s = ZERO_C;
        end else if (cnt_j_r == n_m1_s) begin
          cnt_j_s = ZERO_C;
          if (cnt_i_r == n_m1_s) begin
            state_s = ST_DRAIN;
            cnt_i_s = ZERO_C;
          end else begin
            cnt_i_s = cnt_i_r + ONE_C;
          end
        end else begin
          cnt_j_s = cnt_j_r + ONE_C;
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else if (!line_busy_s) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_i_s = ZERO_C;
        cnt_j_s = ZERO_C;
      end
    endcase
  end

  // State, counters and status outputs, all registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      n_r           <= ZERO_C;
      cnt_i_r       <= ZERO_C;
      cnt_j_r       <= ZERO_C;
      issue_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      n_r           <= n_s;
      cnt_i_r       <= cnt_i_s;
      cnt_j_r       <= cnt_j_s;
      issue_valid_r <= (state_s == ST_ISSUE);
      busy_r        <= (state_s == ST_ISSUE) || (state_s == ST_DRAIN);
      done_r        <= (state_s == ST_FINISH);
    end
  end

  // Tag delay line: the last stage drives acc_* directly, so a tag presented
  // with an issue appears there PIPE_LAT cycles later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        pipe_r[k] <= TAG_EMPTY;
      end
    end else if (bus.abort && (state_r != ST_IDLE)) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        pipe_r[k] <= TAG_EMPTY;
      end
    end else begin
      pipe_r[0] <= tag_in_s;
      for (int k = 1; k < PIPE_LAT; k++) begin
        pipe_r[k] <= pipe_r[k-1];
      end
    end
  end

  assign bus.rd_addr_i   = cnt_i_r[BODY_ADDR_WIDTH-1:0];
  assign bus.rd_addr_j   = cnt_j_r[BODY_ADDR_WIDTH-1:0];
  assign bus.issue_valid = issue_valid_r;
  assign bus.acc_valid   = pipe_r[PIPE_LAT-1].valid;
  assign bus.acc_i       = pipe_r[PIPE_LAT-1].idx;
  assign bus.acc_self    = pipe_r[PIPE_LAT-1].self_pair;
  assign bus.acc_first   = pipe_r[PIPE_LAT-1].first;
  assign bus.acc_last    = pipe_r[PIPE_LAT-1].last;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_accl_pair_sequencer.sv
// ---------------------------------------------------------------------------
// tb_accl_pair_sequencer
// Directed bench. A per-cycle expectation table is filled from the pass
// rules (pair k of a pass started in cycle s issues in cycle s+1+k as
// (k/n, k%n) and retires PIPE_LAT cycles later) and compared against the DUT
// on every falling edge. BODIES is reduced to 16 so a clamped full pass
// (n == BODIES) stays short.
// ---------------------------------------------------------------------------
module tb_accl_pair_sequencer;

  localparam int BODIES   = 16;
  localparam int BAW      = $clog2(BODIES);
  localparam int PIPE_LAT = 4;
  localparam int MAXC     = 2048;

  logic clk = 1'b0;
  logic rst;
  int   cyc      = 0;
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  bit e_iv   [MAXC];
  int e_ri   [MAXC];
  int e_rj   [MAXC];
  bit e_av   [MAXC];
  int e_ai   [MAXC];
  bit e_self [MAXC];
  bit e_first[MAXC];
  bit e_last [MAXC];
  bit e_busy [MAXC];
  bit e_done [MAXC];

  accl_pair_sequencer_if #(.BODY_ADDR_WIDTH(BAW)) bus ();

  accl_pair_sequencer #(
    .BODIES(BODIES),
    .BODY_ADDR_WIDTH(BAW),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string name, input logic act, input logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0b, expected %0b", name, cyc, act, exp);
    end
  endtask

  task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Fill expectations for a pass whose start is driven during cycle s.
  task automatic plan_pass(input int s, input int n_req);
    int nn;
    nn = (n_req > BODIES) ? BODIES : n_req;
    if (nn == 0) begin
      e_busy[s+1] = 1'b1;
      e_done[s+2] = 1'b1;
    end else begin
      for (int k = 0; k < nn * nn; k++) begin
        int c;
        int a;
        c = s + 1 + k;
        a = c + PIPE_LAT;
        e_iv[c]    = 1'b1;
        e_ri[c]    = k / nn;
        e_rj[c]    = k % nn;
        e_av[a]    = 1'b1;
        e_ai[a]    = k / nn;
        e_self[a]  = ((k / nn) == (k % nn));
        e_first[a] = ((k % nn) == 0);
        e_last[a]  = ((k % nn) == nn - 1);
      end
      for (int t = s + 1; t <= s + nn * nn + PIPE_LAT; t++) begin
        e_busy[t] = 1'b1;
      end
      e_done[s + nn * nn + PIPE_LAT + 1] = 1'b1;
    end
  endtask

  // Abort or reset: nothing of the pass is visible from cycle c onward.
  task automatic cancel_from(input int c);
    for (int t = c; t < MAXC; t++) begin
      e_iv[t] = 1'b0; e_ri[t] = 0; e_rj[t] = 0;
      e_av[t] = 1'b0; e_ai[t] = 0; e_self[t] = 1'b0;
      e_first[t] = 1'b0; e_last[t] = 1'b0;
      e_busy[t] = 1'b0; e_done[t] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic start_pass(input int n, output int s);
    s = cyc;
    bus.num_bodies = (BAW+1)'(n);
    bus.start      = 1'b1;
    plan_pass(s, n);
    tick();
    bus.start = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the expectation table.
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      check1("issue_valid", bus.issue_valid, e_iv[cyc]);
      check1("acc_valid", bus.acc_valid, e_av[cyc]);
      check1("busy", bus.busy, e_busy[cyc]);
      check1("done", bus.done, e_done[cyc]);
      if (e_iv[cyc]) begin
        checkv("rd_addr_i", 32'(bus.rd_addr_i), e_ri[cyc]);
        checkv("rd_addr_j", 32'(bus.rd_addr_j), e_rj[cyc]);
      end
      if (e_av[cyc]) begin
        checkv("acc_i", 32'(bus.acc_i), e_ai[cyc]);
        check1("acc_self", bus.acc_self, e_self[cyc]);
        check1("acc_first", bus.acc_first, e_first[cyc]);
        check1("acc_last", bus.acc_last, e_last[cyc]);
      end
    end
  end

  initial begin
    int s;
    int s2;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_bodies = '0;
    tick();
    chk_en = 1'b1;
    check1("reset_issue_valid", bus.issue_valid, 1'b0);
    check1("reset_acc_valid", bus.acc_valid, 1'b0);
    check1("reset_busy", bus.busy, 1'b0);
    check1("reset_done", bus.done, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    tick();

    // n=3 full pass
    start_pass(3, s);
    check1("model_done14", e_done[s+14], 1'b1);
    check1("model_busy13", e_busy[s+13], 1'b1);
    check1("model_busy14", e_busy[s+14], 1'b0);
    check1("model_self9", e_self[s+9], 1'b1);
    check1("model_first8", e_first[s+8], 1'b1);
    check1("model_last10", e_last[s+10], 1'b1);
    checkv("model_ai11", e_ai[s+11], 32'd2);
    checkv("model_ri4", e_ri[s+4], 32'd1);
    tick_to(s+9);
    checkv("t1_last_i", 32'(bus.rd_addr_i), 32'd2);
    checkv("t1_last_j", 32'(bus.rd_addr_j), 32'd2);
    tick_to(s+14);
    check1("t1_done", bus.done, 1'b1);
    check1("t1_busy_low", bus.busy, 1'b0);
    tick_to(s+16);

    // n=0
    start_pass(0, s);
    check1("model_n0_busy1", e_busy[s+1], 1'b1);
    check1("model_n0_done2", e_done[s+2], 1'b1);
    tick_to(s+2);
    check1("n0_done", bus.done, 1'b1);
    tick_to(s+4);

    // n=1
    start_pass(1, s);
    tick_to(s+5);
    check1("n1_acc_self", bus.acc_self, 1'b1);
    check1("n1_acc_first", bus.acc_first, 1'b1);
    check1("n1_acc_last", bus.acc_last, 1'b1);
    tick_to(s+6);
    check1("n1_done", bus.done, 1'b1);
    tick_to(s+8);

    // abort at cycle 4, restart at cycle 8
    start_pass(3, s);
    tick_to(s+4);
    bus.abort = 1'b1;
    cancel_from(s+5);
    tick();
    bus.abort = 1'b0;
    check1("abort_issue_valid", bus.issue_valid, 1'b0);
    check1("abort_acc_valid", bus.acc_valid, 1'b0);
    check1("abort_busy", bus.busy, 1'b0);
    tick_to(s+8);
    start_pass(3, s2);
    checkv("restart_i", 32'(bus.rd_addr_i), 32'd0);
    checkv("restart_j", 32'(bus.rd_addr_j), 32'd0);
    check1("restart_valid", bus.issue_valid, 1'b1);
    tick_to(s2+16);

    // start and abort together in IDLE: nothing starts
    bus.num_bodies = (BAW+1)'(3);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check1("start_abort_busy", bus.busy, 1'b0);
    tick();
    tick();

    // start re-asserted mid-pass with a different count: ignored
    start_pass(3, s);
    tick_to(s+3);
    bus.start = 1'b1;
    bus.num_bodies = (BAW+1)'(5);
    tick();
    bus.start = 1'b0;
    tick_to(s+14);
    check1("retrig_done", bus.done, 1'b1);
    tick_to(s+16);

    // num_bodies above capacity is clamped to BODIES
    start_pass(BODIES + 4, s);
    tick_to(s + BODIES * BODIES);
    checkv("clamp_last_i", 32'(bus.rd_addr_i), 32'(BODIES - 1));
    checkv("clamp_last_j", 32'(bus.rd_addr_j), 32'(BODIES - 1));
    check1("clamp_last_valid", bus.issue_valid, 1'b1);
    tick_to(s + BODIES * BODIES + PIPE_LAT + 1);
    check1("clamp_done", bus.done, 1'b1);
    tick_to(s + BODIES * BODIES + PIPE_LAT + 3);

    // reset mid-pass
    start_pass(3, s);
    tick_to(s+6);
    rst = 1'b0;
    cancel_from(s+7);
    tick();
    rst = 1'b1;
    check1("rst_issue_valid", bus.issue_valid, 1'b0);
    check1("rst_acc_valid", bus.acc_valid, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    checkv("rst_addr_i", 32'(bus.rd_addr_i), 32'd0);
    checkv("rst_addr_j", 32'(bus.rd_addr_j), 32'd0);
    tick_to(s+21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
